fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter WD_LIMIT, default 15: watchdog limit in cycles. Used only when the watchdog is compiled in. Legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 run  input  1  level; 1 = sequence instructions, 0 = stop at instruction boundary.
REQ-005 pc_addr  input  8  current program counter value.
REQ-006 pc_en  output  1  increment request to program counter.
REQ-007 pc_ack  input  1  program counter has incremented.
REQ-008 mem_req  output  1  instruction fetch request.
REQ-009 mem_addr  output  8  fetch address.
REQ-010 mem_valid  input  1  mem_data valid for the current request.
REQ-011 mem_data  input  8  instruction: [7:4] opcode, [3:0] operand.
REQ-012 instr_valid  output  1  one-cycle strobe: opcode/operand are valid for execute.
REQ-013 opcode  output  4  latched opcode.
REQ-014 operand  output  4  latched operand.
REQ-015 exec_done  input  1  execute stage finished the current instruction.
REQ-016 busy  output  1  high in every state except IDLE and HALT.
REQ-017 halted  output  1  high in HALT.
REQ-018 error  output  1  sticky watchdog error.

Function
REQ-019 The FSM SHALL use states IDLE, FETCH, DECODE, EXEC, ADVANCE, HALT, and ERROR. ERROR exists only when the watchdog is compiled in.
REQ-020 IDLE SHALL go to FETCH on run=1; otherwise it SHALL stay in IDLE.
REQ-021 In FETCH, mem_req=1 and mem_addr=pc_addr SHALL hold until mem_valid=1. On that edge, mem_data SHALL be latched into opcode/operand and the FSM SHALL go to DECODE. The minimum fetch latency is 1 cycle.
REQ-022 DECODE SHALL last 1 cycle. If opcode=4'hF (HLT), the FSM SHALL go to HALT with no instr_valid. Otherwise it SHALL pulse instr_valid for exactly 1 cycle and go to EXEC.
REQ-023 EXEC SHALL wait for exec_done=1, then go to ADVANCE.
REQ-024 ADVANCE SHALL hold pc_en=1 until pc_ack is sampled 1, then deassert pc_en on that same edge. The program counter updates on the falling edge, so this yields exactly one increment per instruction.
REQ-025 On leaving ADVANCE, the FSM SHALL go to FETCH if run=1, else to IDLE. run is sampled only in IDLE and at ADVANCE exit; dropping run mid-instruction SHALL complete that instruction.
REQ-026 HALT SHALL be left only by rst.
REQ-027 mem_valid outside FETCH, exec_done outside EXEC, and pc_ack outside ADVANCE SHALL be ignored.
REQ-028 opcode/operand SHALL be stable from DECODE until the next FETCH completes.
REQ-029 pc_addr wrap from 8'hFF to 8'h00 SHALL require no special handling; the sequencer fetches from 8'h00 normally.

Reset
REQ-030 When rst=1 on a rising edge: state=IDLE; pc_en, mem_req, instr_valid, busy, halted, error = 0; mem_addr, opcode, operand = 0; watchdog count = 0.
REQ-031 rst SHALL take precedence over every other input in every state, including mid-FETCH and mid-ADVANCE.

Configuration
REQ-032 Macro SEQ_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-033 With SEQ_WATCHDOG_EN defined:
- An 8-bit counter SHALL clear on entry to FETCH or ADVANCE and increment each cycle spent waiting in those states.
- When the counter reaches WD_LIMIT without mem_valid or pc_ack, the FSM SHALL go to ERROR, with error=1 and all requests deasserted.
- ERROR SHALL persist until rst.
REQ-034 Without SEQ_WATCHDOG_EN, there SHALL be no counter and no ERROR state. error SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Structure
REQ-035 A shared package SHALL hold the state typedef, the 4-bit opcode constants (including OP_HLT=4'hF), and the instruction field positions.
REQ-036 The watchdog SHALL be a sub-module, seq_watchdog (inputs: clk, rst, clear, tick; output: expired), instantiated only under SEQ_WATCHDOG_EN.

Verification
REQ-037 Basic instruction: pc_addr=8'h00, run=1, mem_valid 2 cycles after mem_req, mem_data=8'h35, exec_done after 3 cycles, pc_ack 1 cycle after pc_en.
- Expected: mem_addr=8'h00; a single instr_valid pulse with opcode=3 and operand=5; pc_en high exactly until pc_ack; FSM returns to FETCH.
REQ-038 Halt: mem_data=8'hF0.
- Expected: halted=1, busy=0, no instr_valid, no pc_en.
- The FSM SHALL stay in HALT with run toggling until rst.
REQ-039 Stop at boundary: run drops during EXEC.
- Expected: the instruction completes including pc_en/pc_ack, then IDLE with busy=0.
REQ-040 Reset mid-operation: rst=1 during FETCH with mem_req=1.
- Expected: next cycle mem_req=0 and state IDLE.
- A late mem_valid=1 SHALL be ignored.
REQ-041 Watchdog: with SEQ_WATCHDOG_EN and WD_LIMIT=4, pc_ack held at 0.
- Expected: error=1 after 4 ADVANCE cycles, pc_en=0, sticky until rst.
- With the macro undefined, error stays 0 and pc_en stays 1.
REQ-042 Wrap-around: pc_addr advances 8'hFE, 8'hFF, 8'h00.
- Expected: fetch addresses 8'hFE, 8'hFF, 8'h00 in order, with no stall or error.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM states, opcode constants, instruction fields.
// ST_ERROR is present only when SEQ_WATCHDOG_EN is defined.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_HALT    = 3'd5
`ifdef SEQ_WATCHDOG_EN
        , ST_ERROR = 3'd6
`endif
    } state_t;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int OPR_MSB = 3;
    localparam int OPR_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic [3:0] instr_opcode(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] instr_operand(input logic [7:0] instr);
        return instr[OPR_MSB:OPR_LSB];
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Wait-cycle watchdog for the fetch sequencer; only instantiated when SEQ_WATCHDOG_EN is defined.
// expired fires during the LIMIT-th consecutive waiting cycle, so the caller leaves on that edge.
module seq_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'h00;
        end else if (tick && count != 8'hFF) begin
            count <= count + 8'h01;
        end
    end

    assign expired = tick && (count >= LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/advance sequencer: FETCH -> DECODE -> EXEC -> ADVANCE, HLT parks in HALT.
// Define SEQ_WATCHDOG_EN to add a wait watchdog that traps stalled FETCH/ADVANCE into ERROR.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int WD_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] pc_addr,
    output logic       pc_en,
    input  logic       pc_ack,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_valid,
    input  logic [7:0] mem_data,
    output logic       instr_valid,
    output logic [3:0] opcode,
    output logic [3:0] operand,
    input  logic       exec_done,
    output logic       busy,
    output logic       halted,
    output logic       error,
    output logic [2:0] state_dbg
);

    // Handshakes: mem_req/mem_valid and pc_en/pc_ack complete on the rising edge where both are 1;
    // the requester holds its request until then and drops it on that same edge.
    state_t state;

    // The program counter is passed straight through so a fetch always sees its latest value.
    assign mem_addr  = mem_req ? pc_addr : 8'h00;
    assign state_dbg = state;

`ifdef SEQ_WATCHDOG_EN
    logic wd_tick;
    logic wd_expired;

    assign wd_tick = (state == ST_FETCH && !mem_valid) || (state == ST_ADVANCE && !pc_ack);

    seq_watchdog #(
        .LIMIT(WD_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!wd_tick),
        .tick   (wd_tick),
        .expired(wd_expired)
    );
`else
    assign error = 1'b0;

    // Limit is meaningless without the watchdog; the block below only documents an illegal value.
    if (WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_wd_limit_out_of_range
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_en       <= 1'b0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            opcode      <= 4'h0;
            operand     <= 4'h0;
`ifdef SEQ_WATCHDOG_EN
            error       <= 1'b0;
`endif
        end else begin
            instr_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_valid) begin
                        opcode  <= instr_opcode(mem_data);
                        operand <= instr_operand(mem_data);
                        mem_req <= 1'b0;
                        state   <= ST_DECODE;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        mem_req <= 1'b0;
                        error   <= 1'b1;
                        state   <= ST_ERROR;
                    end
`endif
                end
                ST_DECODE: begin
                    if (opcode == OP_HLT) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        pc_en <= 1'b1;
                        state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    if (pc_ack) begin
                        pc_en <= 1'b0;
                        if (run) begin
                            mem_req <= 1'b1;
                            state   <= ST_FETCH;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_expired) begin
                        pc_en <= 1'b0;
                        error <= 1'b1;
                        state <= ST_ERROR;
                    end
`endif
                end
                ST_HALT: begin
                end
`ifdef SEQ_WATCHDOG_EN
                ST_ERROR: begin
                end
`endif
                default: begin
                    pc_en   <= 1'b0;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    halted  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: randomized instruction streams against a transaction-level model.
// Watchdog expectations follow SEQ_WATCHDOG_EN as compiled.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] pc_addr;
    logic       pc_en;
    logic       pc_ack;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_valid;
    logic [7:0] mem_data;
    logic       instr_valid;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       exec_done;
    logic       busy;
    logic       halted;
    logic       error;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int iv_total = 0;

    // Program counter model: increments on the falling edge after an accepted pc_en/pc_ack.
    logic [7:0] pc_base  = 8'h00;
    logic [7:0] inc_cnt  = 8'h00;
    logic       ack_flag = 1'b0;
    logic [7:0] model_pc = 8'h00;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] fetch_q[$];

    assign pc_addr = pc_base + inc_cnt;

    fetch_sequencer #(
        .WD_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_addr    (pc_addr),
        .pc_en      (pc_en),
        .pc_ack     (pc_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .operand    (operand),
        .exec_done  (exec_done),
        .busy       (busy),
        .halted     (halted),
        .error      (error),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) ack_flag <= (pc_en === 1'b1) && (pc_ack === 1'b1);
    always @(negedge clk) if (ack_flag) inc_cnt <= inc_cnt + 8'd1;

    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            got_q.push_back({opcode, operand});
            iv_total <= iv_total + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: sim time exceeded, want completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        pc_ack    = 1'b0;
        mem_valid = 1'b0;
        exec_done = 1'b0;
        mem_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc_base  = v - inc_cnt;
        model_pc = v;
    endtask

    // ---------------- driver: one whole instruction ----------------
    task automatic run_instr(input logic [7:0] data, input int mlat, input int elat,
                             input int alat, input bit drop_run);
        int  n;
        int  iv0;
        bit  hlt;
        logic [7:0] got;
        logic [7:0] want;
        hlt = (data[7:4] == 4'hF);
        iv0 = iv_total;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (mem_req !== 1'b1) begin
            $display("FAIL fetch_timeout: mem_req=%b want 1 within 20 cycles", mem_req);
            return;
        end else n_pass++;
        for (int k = 1; k < mlat; k++) begin
            mem_valid = 1'b0;
            mem_data  = 8'($urandom);
            tick();
        end
        n_checks++;
        if (mem_addr !== model_pc || mem_req !== 1'b1)
            $display("FAIL fetch_addr: mem_addr=%h mem_req=%b want %h 1", mem_addr, mem_req, model_pc);
        else n_pass++;
        fetch_q.push_back(mem_addr);
        mem_valid = 1'b1;
        mem_data  = data;
        tick();
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
        n_checks++;
        if ({opcode, operand} !== data || mem_req !== 1'b0)
            $display("FAIL decode_latch: op=%h opr=%h mem_req=%b want %h 0", opcode, operand, mem_req, data);
        else n_pass++;
        tick();
        if (hlt) begin
            n_checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0 || iv_total != iv0)
                $display("FAIL halt_entry: halted=%b busy=%b pc_en=%b iv=%0d want 1 0 0 0",
                         halted, busy, pc_en, iv_total - iv0);
            else n_pass++;
            return;
        end
        if (drop_run) run = 1'b0;
        for (int k = 1; k < elat; k++) begin
            mem_valid = 1'($urandom_range(0, 1));
            pc_ack    = 1'($urandom_range(0, 1));
            tick();
        end
        mem_valid = 1'b0;
        pc_ack    = 1'b0;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        for (int k = 0; k < alat; k++) begin
            n_checks++;
            if (pc_en !== 1'b1) $display("FAIL pc_en_hold: pc_en=%b want 1 (wait %0d)", pc_en, k);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (pc_en !== 1'b1) $display("FAIL pc_en_at_ack: pc_en=%b want 1", pc_en);
        else n_pass++;
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        model_pc = model_pc + 8'd1;
        n_checks++;
        if (pc_en !== 1'b0 || pc_addr !== model_pc)
            $display("FAIL pc_advance: pc_en=%b pc=%h want 0 %h", pc_en, pc_addr, model_pc);
        else n_pass++;
        n_checks++;
        if (mem_req !== run || busy !== run)
            $display("FAIL after_advance: mem_req=%b busy=%b want %b %b", mem_req, busy, run, run);
        else n_pass++;
        n_checks++;
        if (iv_total - iv0 != 1)
            $display("FAIL instr_valid_count: got %0d want 1", iv_total - iv0);
        else n_pass++;
        exp_q.push_back(data);
        want = exp_q.pop_front();
        got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_checks++;
        if (got !== want) $display("FAIL scoreboard: issued %h want %h", got, want);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({pc_en, mem_req, instr_valid, busy, halted, error, mem_addr, opcode, operand} !== 22'h0)
            $display("FAIL reset_outputs: %b want all 0",
                     {pc_en, mem_req, instr_valid, busy, halted, error, mem_addr, opcode, operand});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (state_dbg !== ST_IDLE || mem_req !== 1'b0)
            $display("FAIL idle_hold: state=%0d mem_req=%b want %0d 0", state_dbg, mem_req, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        set_pc(8'h00);
        run = 1'b1;
        run_instr(8'h35, 2, 3, 1, 1'b0);
        n_checks++;
        if (state_dbg !== ST_FETCH || mem_addr !== 8'h01)
            $display("FAIL basic_refetch: state=%0d addr=%h want %0d 01", state_dbg, mem_addr, ST_FETCH);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] d;
        do_reset();
        set_pc(8'($urandom));
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
            run_instr(d, $urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_stop_boundary();
        do_reset();
        set_pc(8'h10);
        run = 1'b1;
        run_instr(8'h21, 1, 3, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (state_dbg !== ST_IDLE || busy !== 1'b0 || mem_req !== 1'b0 || pc_addr !== 8'h11)
                $display("FAIL stop_idle: state=%0d busy=%b req=%b pc=%h want %0d 0 0 11",
                         state_dbg, busy, mem_req, pc_addr, ST_IDLE);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_pc(8'h40);
        run = 1'b1;
        run_instr(8'hF0, 1, 1, 1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run       = 1'($urandom_range(0, 1));
            mem_valid = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            pc_ack    = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (state_dbg !== ST_HALT || halted !== 1'b1 || busy !== 1'b0 || pc_en !== 1'b0 ||
                mem_req !== 1'b0 || instr_valid !== 1'b0)
                $display("FAIL halt_sticky: state=%0d halted=%b busy=%b pc_en=%b req=%b iv=%b",
                         state_dbg, halted, busy, pc_en, mem_req, instr_valid);
            else n_pass++;
        end
        do_reset();
        n_checks++;
        if (state_dbg !== ST_IDLE || halted !== 1'b0)
            $display("FAIL halt_reset: state=%0d halted=%b want %0d 0", state_dbg, halted, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_pc(8'h22);
        run = 1'b1;
        tick();
        tick();
        n_checks++;
        if (mem_req !== 1'b1) $display("FAIL mid_fetch_setup: mem_req=%b want 1", mem_req);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b0 || state_dbg !== ST_IDLE)
            $display("FAIL mid_fetch_reset: mem_req=%b state=%0d want 0 %0d", mem_req, state_dbg, ST_IDLE);
        else n_pass++;
        rst       = 1'b0;
        run       = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 8'h5A;
        exec_done = 1'b1;
        pc_ack    = 1'b1;
        tick();
        tick();
        n_checks++;
        if (state_dbg !== ST_IDLE || {opcode, operand} !== 8'h00 || pc_en !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL late_inputs_ignored: state=%0d op=%h%h pc_en=%b iv=%b",
                     state_dbg, opcode, operand, pc_en, instr_valid);
        else n_pass++;
        mem_valid = 1'b0;
        exec_done = 1'b0;
        pc_ack    = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        want = '{8'hFE, 8'hFF, 8'h00};
        do_reset();
        set_pc(8'hFE);
        fetch_q.delete();
        run = 1'b1;
        for (int i = 0; i < 3; i++)
            run_instr({4'($urandom_range(0, 14)), 4'($urandom)}, 2, 2, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fetch_q.size() <= i || fetch_q[i] !== want[i] || error !== 1'b0)
                $display("FAIL wrap_addr_%0d: got %h err=%b want %h 0",
                         i, (fetch_q.size() > i) ? fetch_q[i] : 8'hxx, error, want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_pc(8'h30);
        run = 1'b1;
        tick();
        mem_valid = 1'b1;
        mem_data  = 8'h12;
        tick();
        mem_valid = 1'b0;
        tick();
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (pc_en !== 1'b1 || error !== 1'b0)
                $display("FAIL wd_wait_%0d: pc_en=%b error=%b want 1 0", k, pc_en, error);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (error !== 1'b1 || pc_en !== 1'b0 || mem_req !== 1'b0 || state_dbg !== ST_ERROR)
            $display("FAIL wd_trip: error=%b pc_en=%b req=%b state=%0d want 1 0 0 %0d",
                     error, pc_en, mem_req, state_dbg, ST_ERROR);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            pc_ack    = 1'($urandom_range(0, 1));
            mem_valid = 1'($urandom_range(0, 1));
            tick();
        end
        pc_ack    = 1'b0;
        mem_valid = 1'b0;
        n_checks++;
        if (error !== 1'b1 || state_dbg !== ST_ERROR)
            $display("FAIL wd_sticky: error=%b state=%0d want 1 %0d", error, state_dbg, ST_ERROR);
        else n_pass++;
        do_reset();
        n_checks++;
        if (error !== 1'b0 || state_dbg !== ST_IDLE)
            $display("FAIL wd_reset: error=%b state=%0d want 0 %0d", error, state_dbg, ST_IDLE);
        else n_pass++;
`else
        for (int k = 1; k <= 30; k++) begin
            n_checks++;
            if (pc_en !== 1'b1 || error !== 1'b0)
                $display("FAIL nowd_wait_%0d: pc_en=%b error=%b want 1 0", k, pc_en, error);
            else n_pass++;
            tick();
        end
        pc_ack = 1'b1;
        tick();
        pc_ack = 1'b0;
        n_checks++;
        if (pc_en !== 1'b0 || error !== 1'b0 || pc_addr !== 8'h31)
            $display("FAIL nowd_release: pc_en=%b error=%b pc=%h want 0 0 31", pc_en, error, pc_addr);
        else n_pass++;
        do_reset();
`endif
        if (got_q.size() > 0) void'(got_q.pop_front());
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        pc_ack    = 1'b0;
        mem_valid = 1'b0;
        exec_done = 1'b0;
        mem_data  = 8'h00;
        test_reset();
        test_basic();
        test_random();
        test_stop_boundary();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_watchdog();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
